ingress_pkt_arbiter: RTL and testbench



---
 rtl/ingress_pkt_arbiter.sv | 238 +++++++++++++++++++++++
 tb/tb_ingress_pkt_arbiter.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ingress_pkt_arbiter.sv
// ingress_pkt_arbiter: merges two ingress packet streams into one output stream.
// Whole packets are granted round-robin. Packets that the source flags invalid
// are discarded and counted per port.
// Define ARB_STRICT_PRIORITY_EN to give port 0 fixed priority over port 1.

// Showahead FIFO with async clear; almostfull is registered alongside usedw.
module ingress_pkt_arbiter_fifo #(
  parameter int unsigned W  = 1,
  parameter int unsigned AW = 4,
  parameter int unsigned AF = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         wr,
  input  logic [W-1:0] din,
  input  logic         rd,
  output logic [W-1:0] q,
  output logic         empty,
  output logic         almostfull
);
  localparam int unsigned DEPTH = 1 << AW;
  localparam int unsigned UW    = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [UW-1:0] used_q, used_d;
  logic          af_q, af_d;
  logic          wr_en, rd_en;

  // Pointer and occupancy update; a full FIFO drops the write
  always_comb begin
    wr_en  = wr && (used_q != UW'(DEPTH));
    rd_en  = rd && (used_q != '0);
    wp_d   = wp_q + AW'(wr_en);
    rp_d   = rp_q + AW'(rd_en);
    used_d = used_q + UW'(wr_en) - UW'(rd_en);
    af_d   = (used_d >= UW'(AF));
  end

  // Control registers, cleared by reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wp_q   <= '0;
      rp_q   <= '0;
      used_q <= '0;
      af_q   <= 1'b0;
    end else begin
      wp_q   <= wp_d;
      rp_q   <= rp_d;
      used_q <= used_d;
      af_q   <= af_d;
    end
  end

  // Storage array, no reset needed
  always_ff @(posedge clk) begin
    if (wr_en) mem[wp_q] <= din;
  end

  assign q          = mem[rp_q];
  assign empty      = (used_q == '0);
  assign almostfull = af_q;
endmodule

module ingress_pkt_arbiter #(
  parameter int unsigned PKT_FIFO_AW   = 8,
  parameter int unsigned AF_THRESH     = 128,
  parameter int unsigned VALID_FIFO_AW = 6
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_p0_pkt_wr,
  input  logic [133:0] in_p0_pkt,
  input  logic         in_p0_valid_wr,
  input  logic         in_p0_valid,
  output logic         out_p0_pkt_almostfull,
  input  logic         in_p1_pkt_wr,
  input  logic [133:0] in_p1_pkt,
  input  logic         in_p1_valid_wr,
  input  logic         in_p1_valid,
  output logic         out_p1_pkt_almostfull,
  output logic         out_arb_pkt_wr,
  output logic [133:0] out_arb_pkt,
  output logic         out_arb_valid_wr,
  output logic         out_arb_valid,
  input  logic         in_arb_pkt_almostfull,
  output logic [15:0]  out_p0_drop_cnt,
  output logic [15:0]  out_p1_drop_cnt
);
  localparam int unsigned PW = 134;
  localparam int unsigned VD = 1 << VALID_FIFO_AW;

  typedef enum logic [1:0] {idle_s, grant_s, xfer_s, drop_s} state_t;

  state_t        state_q, state_d;
  logic          grant_q, grant_d, flag_q, flag_d, last_grant_q, last_grant_d;
  logic          pkt_rd_q, pkt_rd_d;
  logic          out_wr_q, out_wr_d, out_vwr_q, out_vwr_d, out_v_q, out_v_d;
  logic [PW-1:0] out_pkt_q, out_pkt_d;
  logic [15:0]   cnt0_q, cnt0_d, cnt1_q, cnt1_d;

  logic [PW-1:0] pq0, pq1, cur_q;
  logic          pempty0, pempty1, cur_empty;
  logic          vq0, vq1, vempty0, vempty1, vaf0, vaf1, unused_vaf;
  logic          vrd0_c, vrd1_c, elig0, elig1, pick_c, rd_en_c, cur_tail;

  ingress_pkt_arbiter_fifo #(.W(PW), .AW(PKT_FIFO_AW), .AF(AF_THRESH)) u_pkt0 (
    .clk(clk), .reset(reset), .wr(in_p0_pkt_wr), .din(in_p0_pkt),
    .rd(pkt_rd_q && !grant_q), .q(pq0), .empty(pempty0), .almostfull(out_p0_pkt_almostfull));
  ingress_pkt_arbiter_fifo #(.W(PW), .AW(PKT_FIFO_AW), .AF(AF_THRESH)) u_pkt1 (
    .clk(clk), .reset(reset), .wr(in_p1_pkt_wr), .din(in_p1_pkt),
    .rd(pkt_rd_q && grant_q), .q(pq1), .empty(pempty1), .almostfull(out_p1_pkt_almostfull));
  ingress_pkt_arbiter_fifo #(.W(1), .AW(VALID_FIFO_AW), .AF(VD)) u_vld0 (
    .clk(clk), .reset(reset), .wr(in_p0_valid_wr), .din(in_p0_valid),
    .rd(vrd0_c), .q(vq0), .empty(vempty0), .almostfull(vaf0));
  ingress_pkt_arbiter_fifo #(.W(1), .AW(VALID_FIFO_AW), .AF(VD)) u_vld1 (
    .clk(clk), .reset(reset), .wr(in_p1_valid_wr), .din(in_p1_valid),
    .rd(vrd1_c), .q(vq1), .empty(vempty1), .almostfull(vaf1));

  assign unused_vaf = vaf0 ^ vaf1;

  // A complete packet is buffered; forwarding it also needs downstream room
  assign elig0     = !vempty0 && (!vq0 || !in_arb_pkt_almostfull);
  assign elig1     = !vempty1 && (!vq1 || !in_arb_pkt_almostfull);
  assign cur_q     = grant_q ? pq1 : pq0;
  assign cur_empty = grant_q ? pempty1 : pempty0;
  assign rd_en_c   = pkt_rd_q && !cur_empty;
  assign cur_tail  = (cur_q[133:132] == 2'b10);

`ifdef ARB_STRICT_PRIORITY_EN
  assign pick_c = !elig0;
`else
  assign pick_c = (elig0 && elig1) ? !last_grant_q : elig1;
`endif

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= idle_s;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      idle_s:         if (elig0 || elig1) state_d = grant_s;
      grant_s:        state_d = flag_q ? xfer_s : drop_s;
      xfer_s, drop_s: if (rd_en_c && cur_tail) state_d = idle_s;
      default:        state_d = idle_s;
    endcase
  end

  // Output and datapath next values
  always_comb begin
    grant_d      = grant_q;
    flag_d       = flag_q;
    last_grant_d = last_grant_q;
    pkt_rd_d     = pkt_rd_q;
    vrd0_c       = 1'b0;
    vrd1_c       = 1'b0;
    out_wr_d     = 1'b0;
    out_pkt_d    = out_pkt_q;
    out_vwr_d    = 1'b0;
    out_v_d      = 1'b0;
    cnt0_d       = cnt0_q;
    cnt1_d       = cnt1_q;
    case (state_q)
      idle_s: begin
        if (elig0 || elig1) begin
          grant_d = pick_c;
          flag_d  = pick_c ? vq1 : vq0;
          vrd0_c  = !pick_c;
          vrd1_c  = pick_c;
        end
      end
      grant_s: begin
        pkt_rd_d     = 1'b1;
        last_grant_d = grant_q;
      end
      xfer_s: begin
        if (rd_en_c) begin
          out_wr_d  = 1'b1;
          out_pkt_d = cur_q;
          if (cur_tail) begin
            out_vwr_d = 1'b1;
            out_v_d   = 1'b1;
            pkt_rd_d  = 1'b0;
          end
        end
      end
      drop_s: begin
        if (rd_en_c && cur_tail) begin
          pkt_rd_d = 1'b0;
          if (grant_q) begin
            if (cnt1_q != 16'hFFFF) cnt1_d = cnt1_q + 16'd1;
          end else begin
            if (cnt0_q != 16'hFFFF) cnt0_d = cnt0_q + 16'd1;
          end
        end
      end
      default: ;
    endcase
  end

  // Datapath and output registers; last_grant resets to 1 so port 0 goes first
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      grant_q      <= 1'b0;
      flag_q       <= 1'b0;
      last_grant_q <= 1'b1;
      pkt_rd_q     <= 1'b0;
      out_wr_q     <= 1'b0;
      out_pkt_q    <= '0;
      out_vwr_q    <= 1'b0;
      out_v_q      <= 1'b0;
      cnt0_q       <= '0;
      cnt1_q       <= '0;
    end else begin
      grant_q      <= grant_d;
      flag_q       <= flag_d;
      last_grant_q <= last_grant_d;
      pkt_rd_q     <= pkt_rd_d;
      out_wr_q     <= out_wr_d;
      out_pkt_q    <= out_pkt_d;
      out_vwr_q    <= out_vwr_d;
      out_v_q      <= out_v_d;
      cnt0_q       <= cnt0_d;
      cnt1_q       <= cnt1_d;
    end
  end

  assign out_arb_pkt_wr   = out_wr_q;
  assign out_arb_pkt      = out_pkt_q;
  assign out_arb_valid_wr = out_vwr_q;
  assign out_arb_valid    = out_v_q;
  assign out_p0_drop_cnt  = cnt0_q;
  assign out_p1_drop_cnt  = cnt1_q;
endmodule

// File: tb/tb_ingress_pkt_arbiter.sv
// Directed bench for ingress_pkt_arbiter.
module tb_ingress_pkt_arbiter;
  logic         clk = 1'b0;
  logic         reset;
  logic         in_p0_pkt_wr, in_p0_valid_wr, in_p0_valid;
  logic         in_p1_pkt_wr, in_p1_valid_wr, in_p1_valid;
  logic [133:0] in_p0_pkt, in_p1_pkt;
  logic         in_arb_pkt_almostfull;
  logic         out_p0_pkt_almostfull, out_p1_pkt_almostfull;
  logic         out_arb_pkt_wr, out_arb_valid_wr, out_arb_valid;
  logic [133:0] out_arb_pkt;
  logic [15:0]  out_p0_drop_cnt, out_p1_drop_cnt;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  logic [133:0] o_pkt[$];
  logic [1:0]   o_vv[$];
  int           o_cyc[$];

  ingress_pkt_arbiter dut (
    .clk(clk), .reset(reset),
    .in_p0_pkt_wr(in_p0_pkt_wr), .in_p0_pkt(in_p0_pkt),
    .in_p0_valid_wr(in_p0_valid_wr), .in_p0_valid(in_p0_valid),
    .out_p0_pkt_almostfull(out_p0_pkt_almostfull),
    .in_p1_pkt_wr(in_p1_pkt_wr), .in_p1_pkt(in_p1_pkt),
    .in_p1_valid_wr(in_p1_valid_wr), .in_p1_valid(in_p1_valid),
    .out_p1_pkt_almostfull(out_p1_pkt_almostfull),
    .out_arb_pkt_wr(out_arb_pkt_wr), .out_arb_pkt(out_arb_pkt),
    .out_arb_valid_wr(out_arb_valid_wr), .out_arb_valid(out_arb_valid),
    .in_arb_pkt_almostfull(in_arb_pkt_almostfull),
    .out_p0_drop_cnt(out_p0_drop_cnt), .out_p1_drop_cnt(out_p1_drop_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Record every output word with its flag strobes and cycle number
  always @(negedge clk) begin
    if (out_arb_pkt_wr === 1'b1) begin
      o_pkt.push_back(out_arb_pkt);
      o_vv.push_back({out_arb_valid_wr, out_arb_valid});
      o_cyc.push_back(cyc);
    end
  end

  function automatic logic [133:0] mkword(input int p, input int id, input int w, input int n);
    logic [1:0]   code;
    logic [131:0] tag;
    code = (w == 0) ? 2'b01 : ((w == n - 1) ? 2'b10 : 2'b11);
    tag  = 132'(p * 65536 + id * 256 + w);
    return {code, tag};
  endfunction

  task automatic clear_inputs();
    in_p0_pkt_wr = 0; in_p0_pkt = '0; in_p0_valid_wr = 0; in_p0_valid = 0;
    in_p1_pkt_wr = 0; in_p1_pkt = '0; in_p1_valid_wr = 0; in_p1_valid = 0;
    in_arb_pkt_almostfull = 0;
  endtask

  task automatic apply_reset();
    @(posedge clk); #1;
    reset = 0;
    clear_inputs();
    repeat (2) @(posedge clk);
    #1 reset = 1;
    o_pkt.delete(); o_vv.delete(); o_cyc.delete();
  endtask

  // Source side: words one per cycle, then the per-packet flag
  task automatic push_pkt(input int p, input int id, input int n, input logic v);
    for (int w = 0; w < n; w++) begin
      @(posedge clk); #1;
      if (p == 0) begin in_p0_pkt_wr = 1; in_p0_pkt = mkword(p, id, w, n); end
      else        begin in_p1_pkt_wr = 1; in_p1_pkt = mkword(p, id, w, n); end
    end
    @(posedge clk); #1;
    in_p0_pkt_wr = 0; in_p1_pkt_wr = 0;
    if (p == 0) begin in_p0_valid_wr = 1; in_p0_valid = v; end
    else        begin in_p1_valid_wr = 1; in_p1_valid = v; end
    @(posedge clk); #1;
    in_p0_valid_wr = 0; in_p1_valid_wr = 0;
  endtask

  task automatic test_reset();
    reset = 0;
    clear_inputs();
    repeat (3) @(posedge clk);
    #1 reset = 1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (out_arb_pkt_wr !== 1'b0) begin errors++; $display("FAIL reset_wr got %b exp 0", out_arb_pkt_wr); end
    checks++; if (out_arb_pkt !== 134'd0) begin errors++; $display("FAIL reset_pkt got %h exp 0", out_arb_pkt); end
    checks++; if (out_arb_valid_wr !== 1'b0) begin errors++; $display("FAIL reset_vwr got %b exp 0", out_arb_valid_wr); end
    checks++; if (out_arb_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", out_arb_valid); end
    checks++; if (out_p0_pkt_almostfull !== 1'b0) begin errors++; $display("FAIL reset_af0 got %b exp 0", out_p0_pkt_almostfull); end
    checks++; if (out_p1_pkt_almostfull !== 1'b0) begin errors++; $display("FAIL reset_af1 got %b exp 0", out_p1_pkt_almostfull); end
    checks++; if (out_p0_drop_cnt !== 16'd0) begin errors++; $display("FAIL reset_cnt0 got %0d exp 0", out_p0_drop_cnt); end
    checks++; if (out_p1_drop_cnt !== 16'd0) begin errors++; $display("FAIL reset_cnt1 got %0d exp 0", out_p1_drop_cnt); end
  endtask

  task automatic test_single();
    apply_reset();
    push_pkt(0, 1, 4, 1'b1);
    for (int i = 0; i < 50 && o_pkt.size() < 4; i++) @(posedge clk);
    repeat (5) @(posedge clk);
    checks++; if (o_pkt.size() !== 4) begin errors++; $display("FAIL single_count got %0d exp 4", o_pkt.size()); end
    for (int w = 0; w < 4 && w < o_pkt.size(); w++) begin
      checks++; if (o_pkt[w] !== mkword(0, 1, w, 4)) begin errors++; $display("FAIL single_word%0d got %h exp %h", w, o_pkt[w], mkword(0, 1, w, 4)); end
      checks++; if (o_vv[w] !== ((w == 3) ? 2'b11 : 2'b00)) begin errors++; $display("FAIL single_vflag%0d got %b", w, o_vv[w]); end
      if (w > 0) begin
        checks++; if (o_cyc[w] !== o_cyc[0] + w) begin errors++; $display("FAIL single_gap%0d got cycle %0d exp %0d", w, o_cyc[w], o_cyc[0] + w); end
      end
    end
  endtask

  task automatic test_round_robin();
    int ep[6];
    int eid[6];
`ifdef ARB_STRICT_PRIORITY_EN
    ep = '{0, 0, 0, 1, 1, 1}; eid = '{10, 11, 12, 20, 21, 22};
`else
    ep = '{0, 1, 0, 1, 0, 1}; eid = '{10, 20, 11, 21, 12, 22};
`endif
    apply_reset();
    in_arb_pkt_almostfull = 1;
    for (int k = 0; k < 3; k++) push_pkt(0, 10 + k, 3, 1'b1);
    for (int k = 0; k < 3; k++) push_pkt(1, 20 + k, 3, 1'b1);
    repeat (5) @(posedge clk);
    checks++; if (o_pkt.size() !== 0) begin errors++; $display("FAIL rr_held got %0d words exp 0", o_pkt.size()); end
    #1 in_arb_pkt_almostfull = 0;
    for (int i = 0; i < 200 && o_pkt.size() < 18; i++) @(posedge clk);
    repeat (5) @(posedge clk);
    checks++; if (o_pkt.size() !== 18) begin errors++; $display("FAIL rr_count got %0d exp 18", o_pkt.size()); end
    for (int j = 0; j < 6; j++) begin
      for (int w = 0; w < 3; w++) begin
        if (j * 3 + w < o_pkt.size()) begin
          checks++; if (o_pkt[j*3+w] !== mkword(ep[j], eid[j], w, 3)) begin errors++; $display("FAIL rr_pkt%0d_w%0d got %h exp %h", j, w, o_pkt[j*3+w], mkword(ep[j], eid[j], w, 3)); end
          checks++; if (o_vv[j*3+w] !== ((w == 2) ? 2'b11 : 2'b00)) begin errors++; $display("FAIL rr_vflag%0d_w%0d got %b", j, w, o_vv[j*3+w]); end
        end
      end
    end
  endtask

  task automatic test_drop();
    o_pkt.delete(); o_vv.delete(); o_cyc.delete();
    checks++; if (out_p1_drop_cnt !== 16'd0) begin errors++; $display("FAIL drop_cnt_before got %0d exp 0", out_p1_drop_cnt); end
    push_pkt(1, 30, 5, 1'b0);
    repeat (20) @(posedge clk);
    #1;
    checks++; if (o_pkt.size() !== 0) begin errors++; $display("FAIL drop_nowrite got %0d words exp 0", o_pkt.size()); end
    checks++; if (out_p1_drop_cnt !== 16'd1) begin errors++; $display("FAIL drop_cnt1 got %0d exp 1", out_p1_drop_cnt); end
    checks++; if (out_p0_drop_cnt !== 16'd0) begin errors++; $display("FAIL drop_cnt0 got %0d exp 0", out_p0_drop_cnt); end
    push_pkt(1, 31, 3, 1'b1);
    for (int i = 0; i < 50 && o_pkt.size() < 3; i++) @(posedge clk);
    repeat (5) @(posedge clk);
    checks++; if (o_pkt.size() !== 3) begin errors++; $display("FAIL drop_next_count got %0d exp 3", o_pkt.size()); end
    for (int w = 0; w < 3 && w < o_pkt.size(); w++) begin
      checks++; if (o_pkt[w] !== mkword(1, 31, w, 3)) begin errors++; $display("FAIL drop_next_w%0d got %h exp %h", w, o_pkt[w], mkword(1, 31, w, 3)); end
    end
  endtask

  task automatic test_downstream_af();
    int n0;
    o_pkt.delete(); o_vv.delete(); o_cyc.delete();
    in_arb_pkt_almostfull = 1;
    push_pkt(0, 40, 6, 1'b1);
    repeat (10) @(posedge clk);
    checks++; if (o_pkt.size() !== 0) begin errors++; $display("FAIL af_nogrant got %0d words exp 0", o_pkt.size()); end
    #1;
    n0 = cyc;
    in_arb_pkt_almostfull = 0;
    for (int i = 0; i < 50 && o_pkt.size() < 1; i++) @(posedge clk);
    #1 in_arb_pkt_almostfull = 1;
    repeat (12) @(posedge clk);
    #1 in_arb_pkt_almostfull = 0;
    checks++; if (o_pkt.size() !== 6) begin errors++; $display("FAIL af_count got %0d exp 6", o_pkt.size()); end
    if (o_pkt.size() > 0) begin
      checks++; if (o_cyc[0] !== n0 + 3) begin errors++; $display("FAIL af_latency got cycle %0d exp %0d", o_cyc[0], n0 + 3); end
    end
    for (int w = 0; w < 6 && w < o_pkt.size(); w++) begin
      checks++; if (o_pkt[w] !== mkword(0, 40, w, 6)) begin errors++; $display("FAIL af_w%0d got %h exp %h", w, o_pkt[w], mkword(0, 40, w, 6)); end
      if (w > 0) begin
        checks++; if (o_cyc[w] !== o_cyc[0] + w) begin errors++; $display("FAIL af_nostall%0d got cycle %0d exp %0d", w, o_cyc[w], o_cyc[0] + w); end
      end
    end
  endtask

  task automatic test_almostfull();
    apply_reset();
    for (int w = 0; w < 128; w++) begin
      @(posedge clk); #1;
      if (w == 127) begin
        checks++; if (out_p0_pkt_almostfull !== 1'b0) begin errors++; $display("FAIL af127 got %b exp 0", out_p0_pkt_almostfull); end
      end
      in_p0_pkt_wr = 1; in_p0_pkt = mkword(0, 60, w, 128);
    end
    @(posedge clk); #1;
    in_p0_pkt_wr = 0;
    checks++; if (out_p0_pkt_almostfull !== 1'b1) begin errors++; $display("FAIL af128 got %b exp 1", out_p0_pkt_almostfull); end
    checks++; if (out_p1_pkt_almostfull !== 1'b0) begin errors++; $display("FAIL af_p1 got %b exp 0", out_p1_pkt_almostfull); end
    in_p0_valid_wr = 1; in_p0_valid = 0;
    @(posedge clk); #1;
    in_p0_valid_wr = 0;
    repeat (160) @(posedge clk);
    #1;
    checks++; if (out_p0_pkt_almostfull !== 1'b0) begin errors++; $display("FAIL af_drain got %b exp 0", out_p0_pkt_almostfull); end
    checks++; if (out_p0_drop_cnt !== 16'd1) begin errors++; $display("FAIL af_dropcnt got %0d exp 1", out_p0_drop_cnt); end
    checks++; if (o_pkt.size() !== 0) begin errors++; $display("FAIL af_nowrite got %0d words exp 0", o_pkt.size()); end
  endtask

  task automatic test_reset_mid();
    o_pkt.delete(); o_vv.delete(); o_cyc.delete();
    push_pkt(0, 50, 6, 1'b1);
    for (int i = 0; i < 50 && o_pkt.size() < 2; i++) @(posedge clk);
    #1 reset = 0;
    #1;
    checks++; if (o_pkt.size() !== 2) begin errors++; $display("FAIL rmid_pre got %0d words exp 2", o_pkt.size()); end
    checks++; if (out_arb_pkt_wr !== 1'b0) begin errors++; $display("FAIL rmid_wr got %b exp 0", out_arb_pkt_wr); end
    checks++; if (out_arb_pkt !== 134'd0) begin errors++; $display("FAIL rmid_pkt got %h exp 0", out_arb_pkt); end
    checks++; if (out_arb_valid_wr !== 1'b0) begin errors++; $display("FAIL rmid_vwr got %b exp 0", out_arb_valid_wr); end
    checks++; if (out_p0_drop_cnt !== 16'd0) begin errors++; $display("FAIL rmid_cnt0 got %0d exp 0", out_p0_drop_cnt); end
    repeat (2) @(posedge clk);
    #1 reset = 1;
    o_pkt.delete(); o_vv.delete(); o_cyc.delete();
    repeat (10) @(posedge clk);
    checks++; if (o_pkt.size() !== 0) begin errors++; $display("FAIL rmid_leftover got %0d words exp 0", o_pkt.size()); end
    push_pkt(0, 51, 3, 1'b1);
    for (int i = 0; i < 50 && o_pkt.size() < 3; i++) @(posedge clk);
    repeat (5) @(posedge clk);
    checks++; if (o_pkt.size() !== 3) begin errors++; $display("FAIL rmid_count got %0d exp 3", o_pkt.size()); end
    for (int w = 0; w < 3 && w < o_pkt.size(); w++) begin
      checks++; if (o_pkt[w] !== mkword(0, 51, w, 3)) begin errors++; $display("FAIL rmid_w%0d got %h exp %h", w, o_pkt[w], mkword(0, 51, w, 3)); end
    end
  endtask

  initial begin
    reset = 0;
    clear_inputs();
    test_reset();
    test_single();
    test_round_robin();
    test_drop();
    test_downstream_af();
    test_almostfull();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
